// File: rtl/r2sdf_stage.sv
// Radix-2 single-path delay-feedback DIF butterfly stage with twiddle ROM address output.
// Optional macro R2SDF_SCALE_EN: halve sum/difference (floor) instead of saturating them.
module r2sdf_stage #(
  parameter int N     = 64,
  parameter int STAGE = 0,
  parameter int WIDTH = 16,
  parameter int FRAC  = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] in_re,
  input  logic signed [WIDTH-1:0] in_im,
  output logic [5:0]              tw_addr,
  input  logic signed [WIDTH-1:0] tw_re,
  input  logic signed [WIDTH-1:0] tw_im,
  output logic                    out_valid,
  output logic                    out_sof,
  output logic signed [WIDTH-1:0] out_re,
  output logic signed [WIDTH-1:0] out_im
);

  localparam int D  = N >> (STAGE + 1);
  localparam int CW = $clog2(2 * D);
  localparam int AW = (D > 1) ? $clog2(D) : 1;
  localparam int PW = 2 * WIDTH + 1;

  localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [PW-1:0]    RND  = PW'(1) << (FRAC - 1);

  // Streaming handshake: in_valid qualifies in_re/in_im for one cycle, there is no
  // back-pressure; out_valid qualifies out_re/out_im/out_sof one cycle later.

  logic [CW-1:0]           cnt;
  logic                    primed;
  logic                    phase_b;
  logic [AW-1:0]           ptr;
  logic signed [WIDTH-1:0] buf_re [1 << AW];
  logic signed [WIDTH-1:0] buf_im [1 << AW];
  logic signed [WIDTH-1:0] head_re, head_im;
  logic signed [WIDTH:0]   sum_re, sum_im, dif_re, dif_im;
  logic signed [2*WIDTH-1:0] p_ac, p_bd, p_ad, p_bc;
  logic signed [PW-1:0]    mul_re, mul_im;

  function automatic logic signed [WIDTH-1:0] bfly_reduce(input logic signed [WIDTH:0] v);
`ifdef R2SDF_SCALE_EN
    bfly_reduce = v[WIDTH:1];
`else
    if (v[WIDTH] != v[WIDTH-1]) bfly_reduce = v[WIDTH] ? SMIN : SMAX;
    else                        bfly_reduce = v[WIDTH-1:0];
`endif
  endfunction

  function automatic logic signed [WIDTH-1:0] round_sat(input logic signed [PW-1:0] v);
    logic signed [PW-1:0] r;
    r = (v + RND) >>> FRAC;
    if (r > PW'(SMAX))      round_sat = SMAX;
    else if (r < PW'(SMIN)) round_sat = SMIN;
    else                    round_sat = r[WIDTH-1:0];
  endfunction

  // The buffer pointer is the low part of cnt, so a reset realigns both together.
  assign phase_b = cnt[CW-1];
  assign ptr     = AW'(cnt & CW'(D - 1));
  assign tw_addr = phase_b ? 6'd0 : (6'(ptr) << STAGE);
  assign head_re = buf_re[ptr];
  assign head_im = buf_im[ptr];

  always_comb begin
    sum_re = (WIDTH+1)'(head_re) + (WIDTH+1)'(in_re);
    sum_im = (WIDTH+1)'(head_im) + (WIDTH+1)'(in_im);
    dif_re = (WIDTH+1)'(head_re) - (WIDTH+1)'(in_re);
    dif_im = (WIDTH+1)'(head_im) - (WIDTH+1)'(in_im);
    p_ac   = (2*WIDTH)'(head_re) * (2*WIDTH)'(tw_re);
    p_bd   = (2*WIDTH)'(head_im) * (2*WIDTH)'(tw_im);
    p_ad   = (2*WIDTH)'(head_re) * (2*WIDTH)'(tw_im);
    p_bc   = (2*WIDTH)'(head_im) * (2*WIDTH)'(tw_re);
    mul_re = PW'(p_ac) - PW'(p_bd);
    mul_im = PW'(p_ad) + PW'(p_bc);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      primed    <= 1'b0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
    end else begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      if (in_valid) begin
        cnt <= cnt + CW'(1);
        if (cnt == CW'(D - 1)) primed <= 1'b1;
        out_valid <= phase_b | primed;
        out_sof   <= (cnt == CW'(D));
        if (phase_b | primed) begin
          out_re <= phase_b ? bfly_reduce(sum_re) : round_sat(mul_re);
          out_im <= phase_b ? bfly_reduce(sum_im) : round_sat(mul_im);
        end
      end
    end
  end

  // Phase A stores the raw input; phase B replaces it with the difference a - b.
  always_ff @(posedge clk) begin
    if (rst_n && in_valid) begin
      buf_re[ptr] <= phase_b ? bfly_reduce(dif_re) : in_re;
      buf_im[ptr] <= phase_b ? bfly_reduce(dif_im) : in_im;
    end
  end

endmodule

// File: doc/r2sdf_stage.md
# r2sdf_stage

Radix-2 single-path delay-feedback (R2SDF) decimation-in-frequency butterfly stage for the 64-point FFT pipeline. It accepts one complex Q6.10 sample per valid cycle and drives the 6-bit twiddle address into the combinational twiddle ROM. It applies the returned twiddle to the difference branch and emits one complex sample per valid input once primed. Six instances, with STAGE 0..5, chain in series.

## Interface
- `N`, 64: FFT length; power of two, at most 64.
- `STAGE`, 0: stage index 0..log2(N)-1. Delay depth is D = N >> (STAGE+1).
- `WIDTH`, 16: sample and twiddle width, signed two's complement.
- `FRAC`, 10: fractional bits of the twiddle (1.0 = 0x0400).

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  a sample is present this cycle; no back-pressure.
- `in_re`, `in_im`  in  WIDTH  input sample.
- `tw_addr`  out  6  twiddle ROM index, combinational from the internal counter.
- `tw_re`, `tw_im`  in  WIDTH  twiddle returned combinationally, same cycle.
- `out_valid`  out  1  output sample valid.
- `out_sof`  out  1  first sample of an output frame.
- `out_re`, `out_im`  out  WIDTH  output sample.

## Operation
**Counter and buffer**
- `cnt` is log2(2D) bits and increments on each `in_valid`, wrapping at 2D.
- Phase A is `cnt` < D; phase B is `cnt` >= D.
- The delay buffer holds D complex entries. It advances only on `in_valid`, and its read and write pointer wraps at D.

**Phase A (`cnt` < D)**
- Write the input into the buffer.
- Read the oldest entry (a stored difference) as `d`.
- Output = round(`d` × tw). `tw_addr` = (`cnt` mod D) << STAGE.

**Phase B (`cnt` >= D)**
- Let `a` be the buffer head and `b` the input.
- Output = `a` + `b`, with no twiddle applied.
- Write `a` − `b` into the buffer.
- `tw_addr` is driven as 0 in this phase; its value is don't-care.

**Arithmetic**
- Sum and difference are computed at WIDTH+1 bits, then reduced to WIDTH as described under Configuration.
- Complex multiply: re = ac − bd, im = ad + bc, using 2·WIDTH-bit products and a 2·WIDTH+1-bit sum.
- Rounding adds 1 << (FRAC−1), then shifts arithmetic-right by FRAC, then saturates to [−2^(WIDTH−1), 2^(WIDTH−1)−1].

**Priming**
- A `primed` flag sets when `cnt` first wraps D−1 → D after reset.
- While not primed, phase-A outputs are suppressed (`out_valid` = 0).
- Once primed, every valid input produces exactly one output.
- `out_sof` is asserted with the first phase-B output of each frame, i.e. when `cnt` == D.

**Drain**
- No internal flush. The final frame's differences leave only when the source feeds D further samples; zeros are sufficient.

## Timing
- Reset (`rst_n` = 0 at an edge) clears `cnt`, `primed`, `out_valid`, `out_sof`, `out_re` and `out_im` to 0. Buffer contents are not reset.
- Latency: outputs are registered. A valid input at edge t produces `out_valid` and data at t+1.
- `in_valid` = 0 in a cycle means:
  - `cnt`, the buffer and `primed` hold;
  - `out_valid` and `out_sof` are 0 the next cycle;
  - `out_re` and `out_im` hold their last value.
- Gaps may occur anywhere in a frame. Output values are identical to the gapless case.
- Reset mid-frame discards the partial frame. After reset, D valid inputs must arrive before the first `out_valid`.
- At `cnt` wrap from 2D−1 to 0, the next phase-A read returns the difference for k = 0 of the frame just completed.
- `tw_addr` is purely a function of `cnt`. The twiddle ROM path is combinational and must meet timing into the output register.

## Configuration
- `R2SDF_SCALE_EN` defined:
  - The sum and difference are arithmetic-shifted right by 1 (floor) before storage or output. This gives a total 1/N scaling across the chain.
  - No saturation is needed at the butterfly.
- `R2SDF_SCALE_EN` undefined:
  - The sum and difference saturate to WIDTH.
  - The multiply path saturates as specified under Arithmetic.

## Test plan
All scenarios use N=64, STAGE=0 (D=32) and gapless input unless stated. Each frame is followed by a 32-zero drain.

1. **Impulse, scale on.** Input x[0]=0x0400, all other samples 0.
   - Outputs after priming: sum k=0 = 0x0200 with `out_sof`=1, sums k=1..31 = 0.
   - Then diff k=0 = 0x0200 + j0, remaining diffs = 0.
2. **DC, scale on.** All 64 samples = 0x0100 + j0.
   - All 32 sums = 0x0100.
   - All 32 diffs = 0.
3. **Twiddle path, scale on.** Input x[1]=0x0400, all other samples 0.
   - `tw_addr` = 1 during diff k=1.
   - Output re = 0x01FE, im = 0xFFCE.
4. **Saturation, scale off.** Input x[0]=x[32]=0x7FFF.
   - Sum k=0 = 0x7FFF.
   - Diff k=0 = 0.
5. **Reset mid-frame.** Drop `rst_n` for 1 cycle after 10 inputs.
   - `out_valid` = 0 the next cycle.
   - The first `out_valid` comes 1 cycle after the 33rd post-reset valid input, with `out_sof` = 1.
6. **Gaps.** Deassert `in_valid` for 5 cycles at sample 40 of the scenario-3 stimulus.
   - `out_valid` = 0 during the gap.
   - The output sequence matches scenario 3 exactly.
